// File: rtl/img_proc_pkg.sv
// Shared definitions for the 3x3 image-processing pipeline.
// Window element order is row-major: k = 3*row + col, with the centre at k = 4.
package img_proc_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam int WIN_TL = 0;
  localparam int WIN_T  = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_L  = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_R  = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_B  = 7;
  localparam int WIN_BR = 8;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    STREAM   = 2'd2
  } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// Single-clock line RAM with one write port and one registered read port.
// A read and a write to the same address in the same cycle return the old data.
// Ports:
//   clk      - clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_re     - read enable; o_rdata updates only when it is set
//   i_raddr  - read address
//   o_rdata  - registered read data
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // The RAM is not reset; its contents are don't-care until rewritten.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator. It takes a raster-order pixel stream,
// keeps the two previous lines and emits one registered window per interior pixel.
// Ports:
//   clk, rst    - clock; synchronous active-high reset
//   in_valid    - pixel strobe; there is no backpressure
//   in_sof      - marks pixel (0,0); restarts the frame when it arrives mid-frame
//   in_pixel    - pixel data
//   win_valid   - window strobe, one cycle after the accepting edge
//   win_sof     - window centred at (1,1)
//   win_eol     - window centred in column IMG_WIDTH-2
//   win_flat    - 9 packed pixels, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   frame_done  - final window of a frame
module window_3x3_gen
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [DATA_WIDTH-1:0]   in_pixel,
  output logic                    win_valid,
  output logic                    win_sof,
  output logic                    win_eol,
  output logic [9*DATA_WIDTH-1:0] win_flat,
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  win_state_t r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  // Two previous columns; [0]=row r-2, [1]=row r-1, [2]=current row.
  logic [2:0][DATA_WIDTH-1:0] r_col_a, r_col_b;

  logic w_restart, w_accept, w_col_last, w_emit;
  logic [CW-1:0] w_pix_col, w_next_col;
  logic [DATA_WIDTH-1:0] w_lb0_q, w_lb1_q;
  logic [2:0][DATA_WIDTH-1:0] w_col_new;
  logic [8:0][DATA_WIDTH-1:0] w_win;

  assign w_restart  = in_valid & in_sof;
  assign w_accept   = in_valid & (in_sof | (r_state != WAIT_SOF));
  // A restart pixel is (0,0) whatever the counters say.
  assign w_pix_col  = w_restart ? '0 : r_col;
  assign w_col_last = (w_pix_col == COL_LAST);
  assign w_next_col = w_col_last ? '0 : w_pix_col + CW'(1);
  assign w_emit     = w_accept & ~w_restart & (r_state == STREAM) & (r_col >= CW'(2));

  // The RAM read port is registered, so each accept prefetches the column that
  // the next accept will consume. The next column is never written before that
  // accept, so the prefetched data stays correct across idle gaps. The lb0
  // write data is the prefetched lb1 value, which preserves read-before-write.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb0 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (w_pix_col),
    .i_wdata (w_lb1_q),
    .i_re    (w_accept),
    .i_raddr (w_next_col),
    .o_rdata (w_lb0_q)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb1 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (w_pix_col),
    .i_wdata (in_pixel),
    .i_re    (w_accept),
    .i_raddr (w_next_col),
    .o_rdata (w_lb1_q)
  );

  assign w_col_new = {in_pixel, w_lb1_q, w_lb0_q};

  always_comb begin
    w_win         = '0;
    w_win[WIN_TL] = r_col_a[0];
    w_win[WIN_T]  = r_col_b[0];
    w_win[WIN_TR] = w_col_new[0];
    w_win[WIN_L]  = r_col_a[1];
    w_win[WIN_C]  = r_col_b[1];
    w_win[WIN_R]  = w_col_new[1];
    w_win[WIN_BL] = r_col_a[2];
    w_win[WIN_B]  = r_col_b[2];
    w_win[WIN_BR] = w_col_new[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= WAIT_SOF;
      r_col      <= '0;
      r_row      <= '0;
      r_col_a    <= '0;
      r_col_b    <= '0;
      win_valid  <= 1'b0;
      win_sof    <= 1'b0;
      win_eol    <= 1'b0;
      frame_done <= 1'b0;
      win_flat   <= '0;
    end else begin
      win_valid  <= w_emit;
      win_sof    <= w_emit & (r_row == RW'(2)) & (r_col == CW'(2));
      win_eol    <= w_emit & w_col_last;
      frame_done <= w_emit & w_col_last & (r_row == ROW_LAST);
      if (w_emit) win_flat <= w_win;

      if (w_accept) begin
        r_col_a <= r_col_b;
        r_col_b <= w_col_new;
        r_col   <= w_next_col;
        if (w_restart) begin
          r_state <= FILL;
          r_row   <= '0;
        end else begin
          case (r_state)
            FILL: if (w_col_last) begin
              r_row <= r_row + RW'(1);
              if (r_row == RW'(1)) r_state <= STREAM;
            end
            STREAM: if (w_col_last) begin
              if (r_row == ROW_LAST) begin
                r_row   <= '0;
                r_state <= WAIT_SOF;
              end else begin
                r_row <= r_row + RW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_pixel;
  logic          win_valid, win_sof, win_eol, frame_done;
  logic [9*DW-1:0] win_flat;

  typedef struct {
    logic [9*DW-1:0] flat;
    logic sof, eol, done;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int n_win = 0;
  int n_done = 0;
  logic prev_v = 1'b0;
  logic [9*DW-1:0] last_sof_flat = '0;
  logic [9*DW-1:0] last_done_flat = '0;

  window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .win_valid  (win_valid),
    .win_sof    (win_sof),
    .win_eol    (win_eol),
    .win_flat   (win_flat),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // in_valid as seen by the most recent edge
  always @(posedge clk) prev_v <= in_valid;

  // Scoreboard: every valid window must match the head of the queue.
  always @(negedge clk) begin
    if (win_valid) begin
      exp_t e;
      n_win++;
      if (frame_done) n_done++;
      if (win_sof) last_sof_flat = win_flat;
      if (frame_done) last_done_flat = win_flat;
      check("valid_follows_accept", 72'(prev_v), 72'(1));
      check("window_expected", 72'(q.size() > 0), 72'(1));
      if (q.size() > 0) begin
        e = q.pop_front();
        check("win_flat", win_flat, e.flat);
        check("win_sof", 72'(win_sof), 72'(e.sof));
        check("win_eol", 72'(win_eol), 72'(e.eol));
        check("frame_done", 72'(frame_done), 72'(e.done));
      end
    end else begin
      check("flags_gated", {69'd0, win_sof, win_eol, frame_done}, 72'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  // Drives the first npix pixels of a frame (value = 4*row+col, in_sof on
  // pixel 0) and queues the window each interior pixel should produce.
  task automatic drive_frame(input int gap, input int npix);
    for (int p = 0; p < npix; p++) begin
      int r, c;
      r = p / W;
      c = p % W;
      step();
      in_valid = 1'b1;
      in_sof   = (p == 0);
      in_pixel = DW'(p);
      if (r >= 2 && c >= 2) begin
        exp_t e;
        e.flat = '0;
        for (int k = 0; k < 9; k++)
          e.flat[k*DW +: DW] = DW'((r - 2 + k / 3) * W + (c - 2 + k % 3));
        e.sof  = (r == 2 && c == 2);
        e.eol  = (c == W - 1);
        e.done = (r == H - 1 && c == W - 1);
        q.push_back(e);
      end
      for (int g = 0; g < gap; g++) begin
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
    end
  endtask

  task automatic expect_counts(input string tag, input int w0, input int d0, input int nw, input int nd);
    check({tag, "_windows"}, 72'(n_win - w0), 72'(nw));
    check({tag, "_frame_done"}, 72'(n_done - d0), 72'(nd));
    check({tag, "_queue_empty"}, 72'(q.size()), 72'(0));
  endtask

  initial begin
    int w0, d0;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    idle(3);
    check("reset_outputs", {68'd0, win_valid, win_sof, win_eol, frame_done}, 72'd0);
    check("reset_flat", win_flat, 72'd0);
    rst = 1'b0;
    idle(2);

    // basic frame
    w0 = n_win; d0 = n_done;
    drive_frame(0, 16);
    idle(3);
    expect_counts("basic", w0, d0, 4, 1);
    check("basic_first_window", last_sof_flat, 72'h0a0908060504020100);
    check("basic_last_window", last_done_flat, 72'h0f0e0d0b0a0907_0605);

    // 3-cycle gap after every pixel
    w0 = n_win; d0 = n_done;
    drive_frame(3, 16);
    idle(3);
    expect_counts("gaps", w0, d0, 4, 1);

    // pixels before any in_sof are discarded
    w0 = n_win; d0 = n_done;
    for (int i = 0; i < 7; i++) begin
      step();
      in_valid = 1'b1; in_sof = 1'b0; in_pixel = DW'(200 + i);
    end
    drive_frame(0, 16);
    idle(3);
    expect_counts("pre_sof", w0, d0, 4, 1);

    // in_sof at pixel 6 restarts the frame
    w0 = n_win; d0 = n_done;
    drive_frame(0, 6);
    drive_frame(0, 16);
    idle(3);
    expect_counts("resync", w0, d0, 4, 1);

    // reset the cycle after pixel 10 is accepted
    w0 = n_win; d0 = n_done;
    drive_frame(0, 11);
    step();
    in_valid = 1'b0; in_sof = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_outputs", {68'd0, win_valid, win_sof, win_eol, frame_done}, 72'd0);
    check("midreset_flat", win_flat, 72'd0);
    drive_frame(0, 16);
    idle(3);
    expect_counts("midreset", w0, d0, 5, 1);

    // two back-to-back frames
    w0 = n_win; d0 = n_done;
    drive_frame(0, 16);
    drive_frame(0, 16);
    idle(3);
    expect_counts("b2b", w0, d0, 8, 2);
    check("b2b_first_window", last_sof_flat, 72'h0a0908060504020100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of the 3x3 filter stages (Laplacian, Sobel, etc.).
- Accepts a raster-order pixel stream, one pixel per accepted cycle, and buffers two previous lines.
- Emits one registered 3x3 window per interior pixel, with valid and framing flags.
- Border pixels (first/last row and column) produce no window; downstream sees (IMG_WIDTH-2)x(IMG_HEIGHT-2) windows per frame.

Parameters:
- DATA_WIDTH, 8, pixel bit width.
- IMG_WIDTH, 640, pixels per line (>=3).
- IMG_HEIGHT, 480, lines per frame (>=3).

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_pixel is valid this cycle; always accepted (no backpressure).
- in_sof  input  1  qualifies in_valid; marks pixel (0,0) of a frame.
- in_pixel  input  DATA_WIDTH  raster-order pixel.
- win_valid  output  1  window bus valid this cycle.
- win_sof  output  1  first window of frame (centre (1,1)).
- win_eol  output  1  last window of a line (centre column IMG_WIDTH-2).
- win_flat  output  9*DATA_WIDTH  window, row-major; element k at [k*DATA_WIDTH +: DATA_WIDTH]; k=4 is centre, k=0 top-left, k=8 bottom-right.
- frame_done  output  1  one-cycle pulse when the final window of a frame is emitted.

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, col/row counters 0, shift registers 0, FSM to WAIT_SOF. Line-buffer RAM contents not cleared (don't-care).
- FSM states:
  - WAIT_SOF: in_valid without in_sof is discarded. in_valid&in_sof -> accept pixel as (0,0), go FILL.
  - FILL: rows 0..1 written into line buffers, no windows. After pixel (1,IMG_WIDTH-1) go STREAM.
  - STREAM: rows 2..IMG_HEIGHT-1. After pixel (IMG_HEIGHT-1,IMG_WIDTH-1) go WAIT_SOF.
- Counters:
  - col wraps IMG_WIDTH-1 -> 0 and increments row.
  - row/col advance only on in_valid; idle cycles hold all state (gaps allowed anywhere).
- Line buffers:
  - Two buffers, depth IMG_WIDTH, indexed by col. lb1 holds row r-1, lb0 holds row r-2.
  - On accept: read both at col, write lb0<=lb1[col] and lb1<=in_pixel (read-before-write, same cycle).
  - The three column values (lb0, lb1, in_pixel) shift into a 3-deep column shift register; the oldest column drops out.
- Window emission:
  - On an accept in STREAM with col>=2, the next cycle has win_valid=1 and win_flat holds the window centred at (row-1,col-1).
  - Latency: exactly 1 cycle from the accepting edge to valid output.
  - win_valid is 0 on every other cycle; win_flat holds its last value when invalid.
- Flags:
  - win_sof=1 with the window for centre (1,1).
  - win_eol=1 with the window for centre col IMG_WIDTH-2.
  - frame_done=1 with the window for centre (IMG_HEIGHT-2,IMG_WIDTH-2).
  - All flags gated by win_valid.
- Re-sync: in_sof asserted in FILL or STREAM aborts the current frame.
  - That pixel becomes (0,0), FSM goes FILL.
  - No frame_done is emitted for the aborted frame.
  - Any window already registered from the previous edge still completes.
- Reset mid-frame: synchronous clear as above; the next frame needs in_sof.
- Widths: counters sized $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). No arithmetic on pixel data.

Decomposition:
- Shared package img_proc_pkg:
  - default DATA_WIDTH
  - window index constants WIN_TL=0 … WIN_C=4 … WIN_BR=8
  - FSM state typedef win_state_t {WAIT_SOF, FILL, STREAM}
- Sub-module line_buffer: single-clock RAM, depth/width parameters, same-address read-before-write, registered read port. Instantiated twice.

Test Plan:
All tests use IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 4*row+col, in_valid continuous.
- Basic frame, values 0..15, in_sof on 0 -> exactly 4 windows. First window (cycle after pixel 10) has win_flat k0..8 = 0,1,2,4,5,6,8,9,10 with win_sof=1. Last window = 5,6,7,9,10,11,13,14,15 with win_eol=1 and frame_done=1.
- Same frame with a 3-cycle in_valid gap after every pixel -> identical window sequence and flags; win_valid never asserted during gaps.
- Pixels streamed before any in_sof, then a frame -> pre-sof pixels ignored; output matches the basic test.
- in_sof reasserted at pixel 6 of frame 1, then a full frame -> no windows and no frame_done from frame 1; frame 2 produces the 4 expected windows.
- rst pulsed high one cycle after pixel 10 is accepted, then a full frame -> outputs 0 the cycle after reset; the next frame yields the 4 correct windows.
- Two back-to-back frames with no idle cycles -> 8 windows; frame 2's first window again has win_sof=1 and content 0,1,2,4,5,6,8,9,10.
